// File: rtl/match_if.sv
// match_if: control, feature-RAM, distance-unit and match-output
// signals of the stereo matcher sequencer.
interface match_if #(
  parameter int ADDR_W = 10,
  parameter int COOR_W = 10,
  parameter int DIST_W = 16
);
  logic                start;
  logic [ADDR_W:0]     n_left;
  logic [ADDR_W:0]     n_right;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   l_addr;
  logic                l_rd;
  logic [2*COOR_W-1:0] l_coor;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd;
  logic [2*COOR_W-1:0] r_coor;
  logic                cmp_issue;
  logic [DIST_W-1:0]   cmp_dist;
  logic                cmp_dist_valid;
  logic [6*COOR_W-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    input  start, n_left, n_right, l_coor, r_coor,
    input  cmp_dist, cmp_dist_valid, dout_ready,
    output busy, done, l_addr, l_rd, r_addr, r_rd,
    output cmp_issue, dout, dout_valid
  );

  modport slave (
    output start, n_left, n_right, l_coor, r_coor,
    output cmp_dist, cmp_dist_valid, dout_ready,
    input  busy, done, l_addr, l_rd, r_addr, r_rd,
    input  cmp_issue, dout, dout_valid
  );
endinterface

// File: rtl/match_ctrl.sv
// match_ctrl: stereo feature-point matcher sequencer. Scans all right
// points per left point, keeps the lowest distance, emits match words.
module match_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int COOR_W  = 10,
  parameter int DIST_W  = 16,
  parameter int CMP_LAT = 3,
  parameter int Y_TOL   = 2,
  parameter logic [DIST_W-1:0] MAX_DIST = 16'd400
) (
  input logic     clk,
  input logic     rst,
  match_if.master bus_io
);
  localparam int CW = COOR_W;
  localparam int NW = ADDR_W + 1;
  localparam logic [CW-1:0] YTOL = CW'(Y_TOL);
  localparam logic [NW-1:0] DRN  = NW'(CMP_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_EMIT, S_FIN
  } state_t;

  state_t            st_q, st_d;
  logic [NW-1:0]     nl_q, nl_d, nr_q, nr_d, j_q, j_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [2*CW-1:0]   l_q, l_d, br_q, br_d;
  logic [DIST_W-1:0] bd_q, bd_d;
  logic              hit_q, hit_d;
  logic              rv_q;
  logic [CMP_LAT-1:0] tv_q;
  logic [2*CW-1:0]   tc_q [CMP_LAT];

  logic [CW-1:0] lx, ly, rx, ry, bx, by, dy_abs;
  logic issue, upd, emit_ok, last_l, dv;

  assign lx = l_q[2*CW-1:CW];
  assign ly = l_q[CW-1:0];
  assign rx = bus_io.r_coor[2*CW-1:CW];
  assign ry = bus_io.r_coor[CW-1:0];
  assign bx = br_q[2*CW-1:CW];
  assign by = br_q[CW-1:0];

  // rv_q marks the cycle in which r_coor holds a freshly read point
  assign dy_abs  = (ly >= ry) ? ly - ry : ry - ly;
  assign issue   = rv_q && (dy_abs <= YTOL);
  assign upd     = bus_io.cmp_dist_valid && tv_q[CMP_LAT-1]
                && (bus_io.cmp_dist < bd_q);
  assign emit_ok = hit_q && (bd_q < MAX_DIST);
  assign last_l  = (NW'(i_q) + NW'(1)) == nl_q;
  assign dv      = (st_q == S_EMIT) && emit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q <= 1'b0;
      tv_q <= '0;
      for (int k = 0; k < CMP_LAT; k++) tc_q[k] <= '0;
    end else begin
      rv_q    <= (st_q == S_SCAN);
      tv_q[0] <= issue;
      tc_q[0] <= bus_io.r_coor;
      for (int k = 1; k < CMP_LAT; k++) begin
        tv_q[k] <= tv_q[k-1];
        tc_q[k] <= tc_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= S_IDLE;
      nl_q  <= '0;
      nr_q  <= '0;
      j_q   <= '0;
      i_q   <= '0;
      l_q   <= '0;
      br_q  <= '0;
      bd_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      nl_q  <= nl_d;
      nr_q  <= nr_d;
      j_q   <= j_d;
      i_q   <= i_d;
      l_q   <= l_d;
      br_q  <= br_d;
      bd_q  <= bd_d;
      hit_q <= hit_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    nl_d  = nl_q;
    nr_d  = nr_q;
    j_d   = j_q;
    i_d   = i_q;
    l_d   = l_q;
    br_d  = br_q;
    bd_d  = bd_q;
    hit_d = hit_q;
    if (upd) begin
      bd_d  = bus_io.cmp_dist;
      br_d  = tc_q[CMP_LAT-1];
      hit_d = 1'b1;
    end
    unique case (st_q)
      S_IDLE: begin
        if (bus_io.start) begin
          nl_d = bus_io.n_left;
          nr_d = bus_io.n_right;
          i_d  = '0;
          j_d  = '0;
          st_d = (bus_io.n_left == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        bd_d  = '1;
        hit_d = 1'b0;
        j_d   = j_q + NW'(1);
        if (j_q[0]) begin
          l_d  = bus_io.l_coor;
          j_d  = '0;
          st_d = (nr_q == '0) ? S_DRAIN : S_SCAN;
        end
      end
      S_SCAN: begin
        j_d = j_q + NW'(1);
        if (j_q == nr_q - NW'(1)) begin
          j_d  = '0;
          st_d = S_DRAIN;
        end
      end
      // one cycle for the last r_coor plus the full compare latency
      S_DRAIN: begin
        j_d = j_q + NW'(1);
        if (j_q == DRN) begin
          j_d  = '0;
          st_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!emit_ok || bus_io.dout_ready) begin
          i_d  = i_q + ADDR_W'(1);
          st_d = last_l ? S_FIN : S_LOAD;
        end
      end
      S_FIN:   st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  assign bus_io.busy       = (st_q != S_IDLE) && (st_q != S_FIN);
  assign bus_io.done       = (st_q == S_FIN);
  assign bus_io.l_addr     = i_q;
  assign bus_io.l_rd       = (st_q == S_LOAD);
  assign bus_io.r_rd       = (st_q == S_SCAN);
  assign bus_io.r_addr     = (st_q == S_SCAN) ? j_q[ADDR_W-1:0] : '0;
  assign bus_io.cmp_issue  = issue;
  assign bus_io.dout_valid = dv;
  assign bus_io.dout       = dv ? {lx - bx, ly - by, br_q, l_q} : '0;
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: table vectors, directed corner sequences and random runs
// of match_ctrl against RAM/distance-unit models and a reference matcher.
module tb_match_ctrl;
  logic clk, rst;
  int vecs, miscmp;

  match_if #(.ADDR_W(10), .COOR_W(10), .DIST_W(16)) m();

  match_ctrl dut (.clk(clk), .rst(rst), .bus_io(m.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [19:0] lram [8];
  logic [19:0] rram [16];
  int          dt [8][16];

  always @(posedge clk) begin
    if (m.l_rd) m.l_coor <= lram[m.l_addr[2:0]];
    if (m.r_rd) m.r_coor <= rram[m.r_addr[3:0]];
  end

  logic [2:0]  pv;
  logic [15:0] pd [3];
  logic [9:0]  r_prev;
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv     <= {pv[1:0], m.cmp_issue};
      pd[0]  <= 16'(dt[m.l_addr[2:0]][r_prev[3:0]]);
      pd[1]  <= pd[0];
      pd[2]  <= pd[1];
      r_prev <= m.r_addr;
    end
  end
  assign m.cmp_dist_valid = pv[2];
  assign m.cmp_dist       = pd[2];

  logic [59:0] got_q [$];
  int n_iss, n_done, n_rd;
  always @(posedge clk) begin
    if (!rst) begin
      if (m.dout_valid && m.dout_ready) got_q.push_back(m.dout);
      if (m.cmp_issue) n_iss++;
      if (m.done) n_done++;
      if (m.l_rd || m.r_rd) n_rd++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [59:0] exp_q [$];

  task automatic model(input int nl, input int nr, output int iss);
    int ly, ry, lx, rx, best, bi, dya;
    exp_q.delete();
    iss = 0;
    for (int l = 0; l < nl; l++) begin
      lx = int'(lram[l][19:10]);
      ly = int'(lram[l][9:0]);
      best = 1 << 20;
      bi = -1;
      for (int r = 0; r < nr; r++) begin
        rx = int'(rram[r][19:10]);
        ry = int'(rram[r][9:0]);
        dya = (ly > ry) ? ly - ry : ry - ly;
        if (dya <= 2) begin
          iss++;
          if (dt[l][r] < best) begin
            best = dt[l][r];
            bi = r;
          end
        end
      end
      if (bi >= 0 && best < 400)
        exp_q.push_back({10'(lx - int'(rram[bi][19:10])),
                         10'(ly - int'(rram[bi][9:0])),
                         rram[bi], lram[l]});
    end
  endtask

  int b_iss, b_done, g_base;

  task automatic run_wait(input int mode, output bit ok);
    bit hv;
    logic [59:0] hw;
    int hc;
    ok = 0;
    hv = 0;
    hw = '0;
    hc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hv) begin
        chk("hold_valid", 64'(m.dout_valid), 64'(1));
        chk("hold_word", 64'(m.dout), 64'(hw));
      end
      if (m.done) begin
        ok = 1;
        break;
      end
      if (mode == 0) m.dout_ready = 1'b1;
      else if (mode == 1) m.dout_ready = 1'($urandom_range(0, 1));
      else if (m.dout_valid && hc < 7) begin
        m.dout_ready = 1'b0;
        hc++;
      end else m.dout_ready = (hc >= 7);
      hv = m.dout_valid && !m.dout_ready;
      hw = m.dout;
      @(negedge clk);
    end
  endtask

  task automatic run_only(input int nl, input int nr, input int mode,
                          input bit dbl, input string nm);
    bit ok;
    b_done = n_done;
    b_iss  = n_iss;
    g_base = got_q.size();
    @(negedge clk);
    m.dout_ready = (mode != 2);
    m.start   = 1'b1;
    m.n_left  = 11'(nl);
    m.n_right = 11'(nr);
    @(negedge clk);
    m.start   = 1'b0;
    m.n_left  = 11'($urandom);
    m.n_right = 11'($urandom);
    if (dbl) begin
      repeat (4) @(negedge clk);
      chk({nm, "_busy"}, 64'(m.busy), 64'(1));
      m.start   = 1'b1;
      m.n_left  = 11'd1;
      m.n_right = 11'd1;
      @(negedge clk);
      m.start = 1'b0;
    end
    run_wait(mode, ok);
    chk({nm, "_finished"}, 64'(ok), 64'(1));
    m.dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk({nm, "_done_cnt"}, 64'(n_done - b_done), 64'(1));
  endtask

  task automatic cmp_model(input string nm, input int iss);
    int n;
    n = got_q.size() - g_base;
    chk({nm, "_nwords"}, 64'(n), 64'(exp_q.size()));
    for (int k = 0; k < n && k < exp_q.size(); k++)
      chk($sformatf("%s_w%0d", nm, k), 64'(got_q[g_base + k]), 64'(exp_q[k]));
    chk({nm, "_issues"}, 64'(n_iss - b_iss), 64'(iss));
  endtask

  typedef struct {
    logic [9:0]  lx, ly, r0x, r0y, r1x, r1y;
    int          d0, d1;
    bit          v;
    logic [59:0] w;
    int          iss;
  } vec_t;

  function automatic vec_t mkv(int lx, int ly, int r0x, int r0y, int r1x,
                               int r1y, int d0, int d1, bit v,
                               logic [59:0] w, int iss);
    vec_t t;
    t.lx = 10'(lx); t.ly = 10'(ly);
    t.r0x = 10'(r0x); t.r0y = 10'(r0y);
    t.r1x = 10'(r1x); t.r1y = 10'(r1y);
    t.d0 = d0; t.d1 = d1; t.v = v; t.w = w; t.iss = iss;
    return t;
  endfunction

  vec_t tv [7];
  int   iss, nl, nr, b_rd;

  initial begin
    vecs = 0; miscmp = 0;
    m.start = 0; m.n_left = '0; m.n_right = '0; m.dout_ready = 0;
    for (int a = 0; a < 8; a++) begin
      lram[a] = '0;
      for (int b = 0; b < 16; b++) dt[a][b] = 0;
    end
    for (int b = 0; b < 16; b++) rram[b] = '0;

    tv[0] = mkv(100, 50, 90, 50, 80, 51, 30, 10, 1,
                {10'd20, 10'h3FF, 10'd80, 10'd51, 10'd100, 10'd50}, 2);
    tv[1] = mkv(5, 9, 15, 9, 7, 10, 10, 10, 1,
                {10'h3F6, 10'd0, 10'd15, 10'd9, 10'd5, 10'd9}, 2);
    tv[2] = mkv(200, 100, 190, 103, 180, 98, 0, 100, 1,
                {10'd20, 10'd2, 10'd180, 10'd98, 10'd200, 10'd100}, 1);
    tv[3] = mkv(10, 10, 10, 20, 10, 0, 5, 5, 0, '0, 0);
    tv[4] = mkv(10, 10, 10, 10, 10, 11, 400, 500, 0, '0, 2);
    tv[5] = mkv(10, 10, 3, 12, 3, 13, 399, 0, 1,
                {10'd7, 10'h3FE, 10'd3, 10'd12, 10'd10, 10'd10}, 1);
    tv[6] = mkv(0, 1, 0, 1023, 0, 0, 1, 50, 1,
                {10'd0, 10'd1, 10'd0, 10'd0, 10'd0, 10'd1}, 1);

    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(m.busy), 0);
    chk("rst_done", 64'(m.done), 0);
    chk("rst_rd", 64'({m.l_rd, m.r_rd}), 0);
    chk("rst_issue", 64'(m.cmp_issue), 0);
    chk("rst_dout", 64'({m.dout_valid, m.dout}), 0);
    chk("rst_addr", 64'({m.l_addr, m.r_addr}), 0);
    rst = 0;

    // empty left image: done right after the start edge, no reads
    b_rd = n_rd;
    g_base = got_q.size();
    @(negedge clk);
    m.start = 1; m.n_left = '0; m.n_right = 11'd4;
    @(negedge clk);
    m.start = 0;
    chk("t1_done_hi", 64'(m.done), 64'(1));
    chk("t1_busy", 64'(m.busy), 0);
    @(negedge clk);
    chk("t1_done_lo", 64'(m.done), 0);
    chk("t1_reads", 64'(n_rd - b_rd), 0);
    chk("t1_words", 64'(got_q.size() - g_base), 0);

    for (int t = 0; t < 7; t++) begin
      lram[0] = {tv[t].lx, tv[t].ly};
      rram[0] = {tv[t].r0x, tv[t].r0y};
      rram[1] = {tv[t].r1x, tv[t].r1y};
      dt[0][0] = tv[t].d0;
      dt[0][1] = tv[t].d1;
      run_only(1, 2, 0, 0, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_nw", t), 64'(got_q.size() - g_base), 64'(tv[t].v));
      if (tv[t].v && got_q.size() > g_base)
        chk($sformatf("tbl%0d_word", t), 64'(got_q[g_base]), 64'(tv[t].w));
      chk($sformatf("tbl%0d_iss", t), 64'(n_iss - b_iss), 64'(tv[t].iss));
    end

    lram[0] = {10'd100, 10'd50};
    lram[1] = {10'd300, 10'd60};
    lram[2] = {10'd500, 10'd70};
    rram[0] = {10'd90, 10'd51};
    rram[1] = {10'd280, 10'd59};
    rram[2] = {10'd480, 10'd70};
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) dt[a][b] = 10 + a + b;
    model(3, 3, iss);
    run_only(3, 3, 2, 0, "t5");
    chk("t5_three", 64'(got_q.size() - g_base), 64'(3));
    cmp_model("t5", iss);

    // abort mid-scan, then a clean rerun
    @(negedge clk);
    m.dout_ready = 1;
    m.start = 1; m.n_left = 11'd3; m.n_right = 11'd3;
    @(negedge clk);
    m.start = 0;
    for (int c = 0; c < 100 && !m.r_rd; c++) @(negedge clk);
    chk("t6_in_scan", 64'(m.r_rd), 64'(1));
    @(negedge clk);
    rst = 1;
    #1;
    chk("t6_busy", 64'(m.busy), 0);
    chk("t6_issue", 64'(m.cmp_issue), 0);
    chk("t6_rd", 64'({m.l_rd, m.r_rd}), 0);
    @(negedge clk);
    rst = 0;
    model(3, 3, iss);
    run_only(3, 3, 0, 0, "t6_rerun");
    cmp_model("t6_rerun", iss);
    run_only(3, 3, 0, 1, "t6_dbl");
    cmp_model("t6_dbl", iss);

    for (int r = 0; r < 14; r++) begin
      for (int a = 0; a < 8; a++) begin
        lram[a] = {10'($urandom), 10'($urandom_range(20, 26))};
        for (int b = 0; b < 16; b++) dt[a][b] = $urandom_range(0, 12) * 40;
      end
      for (int b = 0; b < 16; b++)
        rram[b] = {10'($urandom), 10'($urandom_range(18, 28))};
      nl = $urandom_range(0, 6);
      nr = $urandom_range(0, 10);
      model(nl, nr, iss);
      run_only(nl, nr, 1, 0, $sformatf("rnd%0d", r));
      cmp_model($sformatf("rnd%0d", r), iss);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
